// File: rtl/id_control_issue.sv
// Instruction-decode control and single-slot issue stage with load-use bubble insertion.
// Optional build macro ILLEGAL_OP_TRAP_EN: unknown opcodes set a sticky flag and are dropped.
module id_control_issue #(
  parameter logic [16:0] NOP_CTRL = 17'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  input  logic        flush,
  output logic [16:0] ctrl_out,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_dst,
  output logic [15:0] out_imm,
  output logic        illegal_op,
  output logic [15:0] bubble_cnt
);

  // Operand source encodings
  localparam logic [2:0] SrcRt    = 3'b000;
  localparam logic [2:0] SrcSext  = 3'b001;
  localparam logic [2:0] SrcZext  = 3'b010;
  localparam logic [2:0] SrcLui   = 3'b011;
  localparam logic [2:0] SrcShamt = 3'b100;

  // ALU operation encodings
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluSlt  = 3'b100;
  localparam logic [2:0] AluSll  = 3'b101;
  localparam logic [2:0] AluPass = 3'b110;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic {StRun, StBubble} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [16:0] ctrl_q, ctrl_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  dst_q, dst_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] bcnt_q, bcnt_d;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] f_rs, f_rt, f_rd;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign f_rs   = instr[25:21];
  assign f_rt   = instr[20:16];
  assign f_rd   = instr[15:11];
  assign funct  = instr[5:0];

  // Decoder outputs
  logic [2:0]  d_src, d_alu;
  logic        d_load, d_rf, d_branch, d_store, d_signed, d_jump, d_link, d_dst_rd;
  logic [1:0]  d_size;
  logic        d_legal;
  logic        d_uses_rt;
  logic [16:0] dec_ctrl;
  logic [4:0]  dec_dst;

  always_comb begin
    d_src     = SrcRt;
    d_alu     = AluAdd;
    d_load    = 1'b0;
    d_rf      = 1'b0;
    d_branch  = 1'b0;
    d_store   = 1'b0;
    d_size    = 2'b00;
    d_signed  = 1'b0;
    d_jump    = 1'b0;
    d_link    = 1'b0;
    d_dst_rd  = 1'b0;
    d_legal   = 1'b1;
    d_uses_rt = 1'b0;
    unique case (opcode)
      6'h00: begin
        d_rf      = 1'b1;
        d_dst_rd  = 1'b1;
        d_uses_rt = 1'b1;
        unique case (funct)
          6'h20:   d_alu = AluAdd;
          6'h22:   d_alu = AluSub;
          6'h24:   d_alu = AluAnd;
          6'h25:   d_alu = AluOr;
          6'h2A:   d_alu = AluSlt;
          6'h00: begin
            d_alu = AluSll;
            d_src = SrcShamt;
          end
          default: d_legal = 1'b0;
        endcase
      end
      6'h08: begin
        d_src = SrcSext;
        d_rf  = 1'b1;
      end
      6'h0C: begin
        d_alu = AluAnd;
        d_src = SrcZext;
        d_rf  = 1'b1;
      end
      6'h0D: begin
        d_alu = AluOr;
        d_src = SrcZext;
        d_rf  = 1'b1;
      end
      6'h0F: begin
        d_alu = AluPass;
        d_src = SrcLui;
        d_rf  = 1'b1;
      end
      6'h23: begin
        d_src    = SrcSext;
        d_load   = 1'b1;
        d_rf     = 1'b1;
        d_size   = 2'b10;
        d_signed = 1'b1;
      end
      6'h20: begin
        d_src    = SrcSext;
        d_load   = 1'b1;
        d_rf     = 1'b1;
        d_signed = 1'b1;
      end
      6'h24: begin
        d_src  = SrcSext;
        d_load = 1'b1;
        d_rf   = 1'b1;
      end
      6'h2B: begin
        d_src     = SrcSext;
        d_store   = 1'b1;
        d_size    = 2'b10;
        d_uses_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        d_alu     = AluSub;
        d_branch  = 1'b1;
        d_uses_rt = 1'b1;
      end
      6'h02: d_jump = 1'b1;
      6'h03: begin
        d_jump = 1'b1;
        d_link = 1'b1;
        d_rf   = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  assign dec_ctrl = d_legal ? {d_src, d_alu, d_load, d_rf, d_branch, d_store, d_size, d_signed,
                               d_jump, d_link, d_dst_rd, 1'b1}
                            : NOP_CTRL;
  assign dec_dst  = d_link ? 5'd31 : (d_dst_rd ? f_rd : f_rt);

  // Load-use hazard against the word currently in the slot; suppressed once a bubble is in.
  logic hazard, accept, drain;

  assign hazard = (state_q == StRun) && valid_q && ctrl_q[10] && (dst_q != 5'd0) && in_valid &&
                  ((f_rs == dst_q) || (d_uses_rt && (f_rt == dst_q)));
  assign in_ready = !reset && (!valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    bcnt_d  = bcnt_q;
    if (flush) begin
      state_d = StRun;
      valid_d = 1'b0;
      ctrl_d  = NOP_CTRL;
    end else if (hazard && out_ready) begin
      state_d = StBubble;
      valid_d = 1'b1;
      ctrl_d  = NOP_CTRL;
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      dst_d   = 5'd0;
      imm_d   = 16'd0;
      if (bcnt_q != 16'hFFFF) begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end else begin
      if (drain) begin
        state_d = StRun;
        valid_d = 1'b0;
      end
      if (accept) begin
        valid_d = !(TrapEn && !d_legal);
        ctrl_d  = dec_ctrl;
        rs_d    = f_rs;
        rt_d    = f_rt;
        dst_d   = dec_dst;
        imm_d   = instr[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      dst_q   <= 5'd0;
      imm_q   <= 16'd0;
      bcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (!flush && accept && !d_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign out_valid  = valid_q;
  assign ctrl_out   = ctrl_q;
  assign out_rs     = rs_q;
  assign out_rt     = rt_q;
  assign out_dst    = dst_q;
  assign out_imm    = imm_q;
  assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_id_control_issue.sv
// Directed bench for id_control_issue: decode words, load-use bubble, stall, flush, reset.
module tb_id_control_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic        flush;
  logic [16:0] ctrl_out;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [15:0] out_imm;
  logic        illegal_op;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-computed instruction encodings and their control words
  localparam logic [31:0] I_ADDI = 32'h2009_0005;  // addi $t1,$zero,5
  localparam logic [31:0] I_LW   = 32'h8E08_0000;  // lw $t0,0($s0)
  localparam logic [31:0] I_ADD  = 32'h0109_5020;  // add $t2,$t0,$t1
  localparam logic [31:0] I_BEQ  = 32'h1109_0004;  // beq $t0,$t1,4
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;  // jal 0x10
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 3F
  localparam logic [16:0] C_ADDI = 17'h04201;
  localparam logic [16:0] C_LW   = 17'h04651;
  localparam logic [16:0] C_ADD  = 17'h00203;
  localparam logic [16:0] C_BEQ  = 17'h00901;
  localparam logic [16:0] C_JAL  = 17'h0020D;
  localparam logic [16:0] C_NOP  = 17'h00000;

  id_control_issue dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .flush      (flush),
    .ctrl_out   (ctrl_out),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_dst    (out_dst),
    .out_imm    (out_imm),
    .illegal_op (illegal_op),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", ctrl_out, C_NOP);
    check("rst_dst", out_dst, 0);
    check("rst_imm", out_imm, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_illegal", illegal_op, 0);
    check("idle_in_ready", in_ready, 1);

    // addi issue, then drain
    in_valid = 1'b1;
    instr    = I_ADDI;
    step();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_ctrl", ctrl_out, C_ADDI);
    check("addi_dst", out_dst, 9);
    check("addi_imm", out_imm, 16'h0005);
    step();
    check("drain_valid", out_valid, 0);

    // lw followed by dependent add: one bubble
    in_valid = 1'b1;
    instr    = I_LW;
    step();
    check("lw_ctrl", ctrl_out, C_LW);
    check("lw_dst", out_dst, 8);
    instr = I_ADD;
    #1;
    check("hazard_in_ready", in_ready, 0);
    step();
    check("bubble_valid", out_valid, 1);
    check("bubble_ctrl", ctrl_out, C_NOP);
    check("bubble_cnt1", bubble_cnt, 1);
    check("bubble_in_ready", in_ready, 1);
    step();
    check("add_ctrl", ctrl_out, C_ADD);
    check("add_dst", out_dst, 10);
    check("add_rs", out_rs, 8);
    check("add_rt", out_rt, 9);
    in_valid = 1'b0;
    step();
    check("add_drain", out_valid, 0);

    // Stall with lw in slot for 3 cycles
    in_valid = 1'b1;
    instr    = I_LW;
    step();
    out_ready = 1'b0;
    instr     = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      step();
      check("stall_valid", out_valid, 1);
      check("stall_ctrl", ctrl_out, C_LW);
      check("stall_dst", out_dst, 8);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    step();
    check("unstall_ctrl", ctrl_out, C_ADDI);
    check("unstall_dst", out_dst, 9);
    in_valid = 1'b0;
    step();
    check("unstall_drain", out_valid, 0);

    // Flush with beq in slot
    in_valid = 1'b1;
    instr    = I_BEQ;
    step();
    check("beq_ctrl", ctrl_out, C_BEQ);
    flush = 1'b1;
    instr = I_ADDI;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    step();
    check("flush_not_accepted", out_valid, 0);

    // Flush during a bubble returns the FSM to RUN: the next load-use pair bubbles again
    in_valid = 1'b1;
    instr    = I_LW;
    step();
    instr = I_ADD;
    step();
    check("bubble_cnt2", bubble_cnt, 2);
    flush    = 1'b1;
    in_valid = 1'b0;
    step();
    flush    = 1'b0;
    check("flush_bubble_valid", out_valid, 0);
    in_valid = 1'b1;
    instr    = I_LW;
    step();
    check("relw_ctrl", ctrl_out, C_LW);
    instr = I_ADD;
    #1;
    check("run_hazard_in_ready", in_ready, 0);
    step();
    check("bubble_cnt3", bubble_cnt, 3);
    step();
    check("readd_ctrl", ctrl_out, C_ADD);
    in_valid = 1'b0;
    step();

    // Unknown opcode
    in_valid = 1'b1;
    instr    = I_BAD;
    step();
    in_valid = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    check("bad_valid", out_valid, 0);
    check("bad_illegal", illegal_op, 1);
`else
    check("bad_valid", out_valid, 1);
    check("bad_ctrl", ctrl_out, C_NOP);
    check("bad_illegal", illegal_op, 0);
`endif
    step();

    // jal
    in_valid = 1'b1;
    instr    = I_JAL;
    step();
    in_valid = 1'b0;
    check("jal_ctrl", ctrl_out, C_JAL);
    check("jal_dst", out_dst, 31);

    // Reset during a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = I_ADDI;
    step();
    check("prerst_hold", ctrl_out, C_JAL);
    reset = 1'b1;
    #1;
    check("rst2_in_ready", in_ready, 0);
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rst2_valid", out_valid, 0);
    check("rst2_ctrl", ctrl_out, C_NOP);
    check("rst2_dst", out_dst, 0);
    check("rst2_bubble_cnt", bubble_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
